rv32_regfile_sb: RTL and testbench
==================================

// Module: rv32_regfile_sb
// PURPOSE
//  Parametrised integer register file: NUM_RD combinational read ports, one write port, x0 hardwired to zero.
//  Write-through bypass from the write port to the read ports.
//  Per-register busy scoreboard with stall generation for the issue stage.
//  Reset clears the array with a sequential sweep, one register per cycle.
//  Sits between decode/issue (reads, scoreboard set) and writeback (write, scoreboard clear).
// PARAMETERS
//  XLEN      32  data width of each register
//  DEPTH     32  number of registers (2..2**AW)
//  AW        5   address width; must satisfy 2**AW >= DEPTH
//  NUM_RD    2   number of read ports (1..4)
//  RESET_VAL 0   value written to every register by the reset sweep
//  BYPASS    1   1: write-through forwarding to read ports; 0: read returns array contents only
// PORTS
//  mp_clk_in       in   1            clock, all state updates on rising edge
//  mp_rst_in       in   1            synchronous active-high reset
//  rs_addr_in      in   NUM_RD*AW    read addresses; port k = bits [k*AW +: AW]
//  rs_req_in       in   NUM_RD       port k operand actually needed this cycle (stall qualifier)
//  rs_out          out  NUM_RD*XLEN  read data; port k = bits [k*XLEN +: XLEN]
//  rs_busy_out     out  NUM_RD       port k source has a pending, unforwarded write
//  stall_out       out  1            |(rs_busy_out & rs_req_in) | ~rdy_out
//  iss_vld_in      in   1            instruction issued this cycle, destination iss_rd_addr_in
//  iss_rd_addr_in  in   AW           destination register of issued instruction
//  wr_eb_in        in   1            writeback enable
//  rd_addr_in      in   AW           writeback address
//  rd_in           in   XLEN         writeback data
//  rdy_out         out  1            register file initialised and accepting reads/writes
// BEHAVIOUR
//  FSM INIT/RUN. mp_rst_in=1 at a clock edge -> INIT, sweep counter=0, all busy bits=0.
//    Applies in any state, including mid-sweep, which restarts the sweep.
//  INIT: each cycle write RESET_VAL to mem[cnt], cnt++.
//    Writeback and issue inputs are ignored.
//    After writing index DEPTH-1 -> RUN.
//    rdy_out goes high on the DEPTH-th edge after reset is released.
//  While rdy_out=0: rs_out=0, rs_busy_out=0, stall_out=1.
//  Write (RUN): at posedge, mem[rd_addr_in]<=rd_in when wr_eb_in, rd_addr_in!=0 and rd_addr_in<DEPTH.
//  Read (combinational), port k, address a:
//    a==0 or a>=DEPTH -> 0.
//    Else if BYPASS && wr_eb_in && rd_addr_in==a -> rd_in.
//    Else mem[a].
//  Scoreboard (RUN):
//    iss_vld_in with iss_rd_addr_in!=0 sets busy[iss_rd_addr_in].
//    wr_eb_in clears busy[rd_addr_in].
//    Set and clear to the same address in one cycle: set wins (newer producer).
//    busy[0] is constant 0; addresses >=DEPTH are ignored.
//    A write to a non-busy register is legal and still updates mem.
//  rs_busy_out[k] = busy[a] & ~(BYPASS & wr_eb_in & rd_addr_in==a); 0 for a==0.
//  No internal read latency; write becomes visible in the array on the cycle after the edge.
// TESTING
//  T1 reset 1 cycle, DEPTH=32 -> rdy_out=0 for 32 cycles then 1; all reads return RESET_VAL; x0 reads 0.
//  T2 wr x5=0xDEADBEEF, same cycle rs0=x5 -> rs_out[0]=0xDEADBEEF (BYPASS=1), 0 (BYPASS=0); next cycle both 0xDEADBEEF.
//  T3 write x0=0x1234 -> x0 still reads 0; issue to x0 -> busy never set, stall_out stays 0.
//  T4 issue x7; next cycle rs1=x7, rs_req_in=2'b10 -> stall_out=1; wr x7=9 -> same cycle rs_busy_out[1]=0, rs_out=9.
//    Same test with rs_req_in=0 -> stall_out=0.
//  T5 same cycle issue x3 and wr x3 -> busy[3]=1 afterwards; new wr x3 clears it.
//  T6 reset asserted at sweep index 10 -> sweep restarts at 0; rdy_out high 32 cycles after release; busy all 0.

Source files
------------

// File: rtl/rv32_regfile_sb.sv
// ---------------------------------------------------------------------------
// rv32_regfile_sb
// Integer register file with a busy scoreboard for the issue stage.
//   - NUM_RD combinational read ports, one write port, x0 reads as zero.
//   - Optional write-through bypass from the write port to the read ports.
//   - Per-register busy bits: set on issue, cleared on writeback; stall is
//     raised when a requested operand is still waiting for its producer.
//   - Reset sweeps RESET_VAL into the array, one register per cycle; the
//     block reports ready once the sweep has covered every register.
// Ports
//   mp_clk_in       clock, rising edge
//   mp_rst_in       synchronous active-high reset (restarts the sweep)
//   rs_addr_in      read addresses, port k = [k*AW +: AW]
//   rs_req_in       port k operand needed this cycle (qualifies stall)
//   rs_out          read data, port k = [k*XLEN +: XLEN]
//   rs_busy_out     port k source has a pending, unforwarded write
//   stall_out       requested operand busy, or file not ready
//   iss_vld_in      instruction issued, destination iss_rd_addr_in
//   iss_rd_addr_in  destination register of the issued instruction
//   wr_eb_in        writeback enable
//   rd_addr_in      writeback address
//   rd_in           writeback data
//   rdy_out         sweep complete, reads and writes accepted
// ---------------------------------------------------------------------------
module rv32_regfile_sb #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 32,
  parameter int              AW        = 5,
  parameter int              NUM_RD    = 2,
  parameter logic [XLEN-1:0] RESET_VAL = '0,
  parameter bit              BYPASS    = 1'b1
) (
  input  logic                   mp_clk_in,
  input  logic                   mp_rst_in,
  input  logic [NUM_RD*AW-1:0]   rs_addr_in,
  input  logic [NUM_RD-1:0]      rs_req_in,
  output logic [NUM_RD*XLEN-1:0] rs_out,
  output logic [NUM_RD-1:0]      rs_busy_out,
  output logic                   stall_out,
  input  logic                   iss_vld_in,
  input  logic [AW-1:0]          iss_rd_addr_in,
  input  logic                   wr_eb_in,
  input  logic [AW-1:0]          rd_addr_in,
  input  logic [XLEN-1:0]        rd_in,
  output logic                   rdy_out
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t          state, state_next;
  logic [AW-1:0]   cnt, cnt_next;
  logic [XLEN-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic            wr_ok;
  logic            iss_ok;

  // Addresses at or above DEPTH exist only when DEPTH < 2**AW; they are
  // treated as absent registers everywhere.
  function automatic logic in_range(input logic [AW-1:0] a);
    return (AW+1)'(a) < (AW+1)'(DEPTH);
  endfunction

  assign rdy_out = (state == ST_RUN);
  assign wr_ok   = rdy_out && wr_eb_in && (rd_addr_in != '0) && in_range(rd_addr_in);
  assign iss_ok  = rdy_out && iss_vld_in && (iss_rd_addr_in != '0) && in_range(iss_rd_addr_in);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge mp_clk_in) begin
    if (mp_rst_in) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_INIT: begin
        cnt_next = cnt + 1'b1;
        if (cnt == LAST_IDX) state_next = ST_RUN;
      end
      default: ;
    endcase
  end

  // NOTE: the array has no reset branch; it is initialised by the sweep, which
  // keeps it mappable onto plain RAM/flop arrays without a reset network.
  always_ff @(posedge mp_clk_in) begin
    if (!mp_rst_in) begin
      if (state == ST_INIT) mem[cnt] <= RESET_VAL;
      else if (wr_ok)       mem[rd_addr_in] <= rd_in;
    end
  end

  // Clear is written before set so that, for the same register in one cycle,
  // the issuing (newer) producer keeps the bit set.
  always_ff @(posedge mp_clk_in) begin
    if (mp_rst_in) begin
      busy <= '0;
    end else if (rdy_out) begin
      if (wr_eb_in && in_range(rd_addr_in)) busy[rd_addr_in] <= 1'b0;
      if (iss_ok)                           busy[iss_rd_addr_in] <= 1'b1;
    end
  end

  always_comb begin
    logic [AW-1:0] a;
    logic          fwd;
    rs_out      = '0;
    rs_busy_out = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      a   = rs_addr_in[k*AW +: AW];
      fwd = BYPASS && wr_eb_in && (rd_addr_in == a);
      if (rdy_out && (a != '0) && in_range(a)) begin
        rs_out[k*XLEN +: XLEN] = fwd ? rd_in : mem[a];
        rs_busy_out[k]         = busy[a] & ~fwd;
      end
    end
  end

  assign stall_out = ~rdy_out | (|(rs_busy_out & rs_req_in));

endmodule

// File: tb/tb_rv32_regfile_sb.sv
module tb_rv32_regfile_sb;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 32;
  localparam int          AW    = 5;
  localparam int          NRD   = 2;
  localparam logic [31:0] RVAL  = 32'hC0DE_0001;

  logic              mp_clk_in;
  logic              mp_rst_in;
  logic [NRD*AW-1:0] rs_addr;
  logic [NRD-1:0]    rs_req;
  logic [NRD*XLEN-1:0] rs_data, nb_data;
  logic [NRD-1:0]    rs_busy, nb_busy;
  logic              stall, nb_stall, rdy, nb_rdy;
  logic              iss_vld;
  logic [AW-1:0]     iss_rd;
  logic              wr_eb;
  logic [AW-1:0]     wr_addr;
  logic [XLEN-1:0]   wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  rv32_regfile_sb #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .NUM_RD(NRD),
                    .RESET_VAL(RVAL), .BYPASS(1'b1)) u_dut (
    .mp_clk_in(mp_clk_in), .mp_rst_in(mp_rst_in),
    .rs_addr_in(rs_addr), .rs_req_in(rs_req), .rs_out(rs_data),
    .rs_busy_out(rs_busy), .stall_out(stall),
    .iss_vld_in(iss_vld), .iss_rd_addr_in(iss_rd),
    .wr_eb_in(wr_eb), .rd_addr_in(wr_addr), .rd_in(wr_data),
    .rdy_out(rdy));

  rv32_regfile_sb #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .NUM_RD(NRD),
                    .RESET_VAL(RVAL), .BYPASS(1'b0)) u_nobyp (
    .mp_clk_in(mp_clk_in), .mp_rst_in(mp_rst_in),
    .rs_addr_in(rs_addr), .rs_req_in(rs_req), .rs_out(nb_data),
    .rs_busy_out(nb_busy), .stall_out(nb_stall),
    .iss_vld_in(iss_vld), .iss_rd_addr_in(iss_rd),
    .wr_eb_in(wr_eb), .rd_addr_in(wr_addr), .rd_in(wr_data),
    .rdy_out(nb_rdy));

  initial mp_clk_in = 1'b0;
  always #5 mp_clk_in = ~mp_clk_in;

  // Reference model: register contents, busy flags, sweep progress.
  logic [31:0] m_mem [DEPTH];
  bit          m_busy [DEPTH];
  bit          m_ready = 1'b0;
  int          m_cnt   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (!m_ready || a == 0) return 32'h0;
    if (byp && wr_eb && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a, input bit byp);
    if (!m_ready || a == 0) return 1'b0;
    return m_busy[a] && !(byp && wr_eb && wr_addr == a);
  endfunction

  function automatic bit exp_stall(input bit byp);
    bit s;
    s = !m_ready;
    for (int k = 0; k < NRD; k++)
      if (rs_req[k] && exp_busy(rs_addr[k*AW +: AW], byp)) s = 1'b1;
    return s;
  endfunction

  task automatic update_model();
    if (mp_rst_in) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    end else if (!m_ready) begin
      m_mem[m_cnt] = RVAL;
      m_cnt++;
      if (m_cnt == DEPTH) m_ready = 1'b1;
    end else begin
      if (wr_eb && wr_addr != 0) m_mem[wr_addr] = wr_data;
      if (wr_eb) m_busy[wr_addr] = 1'b0;
      if (iss_vld && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
  endtask

  task automatic check_all();
    logic [AW-1:0] a;
    check("rdy", 64'(rdy), 64'(m_ready));
    check("rdy_nobyp", 64'(nb_rdy), 64'(m_ready));
    check("stall", 64'(stall), 64'(exp_stall(1'b1)));
    check("stall_nobyp", 64'(nb_stall), 64'(exp_stall(1'b0)));
    for (int k = 0; k < NRD; k++) begin
      a = rs_addr[k*AW +: AW];
      check($sformatf("rs_out%0d x%0d", k, a), 64'(rs_data[k*XLEN +: XLEN]), 64'(exp_rd(a, 1'b1)));
      check($sformatf("rs_busy%0d x%0d", k, a), 64'(rs_busy[k]), 64'(exp_busy(a, 1'b1)));
      check($sformatf("nb_rs_out%0d x%0d", k, a), 64'(nb_data[k*XLEN +: XLEN]), 64'(exp_rd(a, 1'b0)));
      check($sformatf("nb_rs_busy%0d x%0d", k, a), 64'(nb_busy[k]), 64'(exp_busy(a, 1'b0)));
    end
  endtask

  task automatic settle();
    @(negedge mp_clk_in);
    check_all();
  endtask

  task automatic clk_edge();
    @(posedge mp_clk_in);
    update_model();
    #1;
  endtask

  task automatic cycle();
    settle();
    clk_edge();
  endtask

  task automatic idle();
    mp_rst_in = 1'b0; rs_addr = '0; rs_req = '0;
    iss_vld = 1'b0; iss_rd = '0; wr_eb = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic rand_inputs(input bit allow_rst);
    rs_addr   = {rand_addr(), rand_addr()};
    rs_req    = NRD'($urandom_range(0, 3));
    iss_vld   = ($urandom_range(0, 9) < 3);
    iss_rd    = rand_addr();
    wr_eb     = ($urandom_range(0, 9) < 4);
    wr_addr   = rand_addr();
    wr_data   = $urandom();
    mp_rst_in = allow_rst && ($urandom_range(0, 599) == 0);
  endtask

  // Releases reset and counts edges until rdy_out, with a bound.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (rdy !== 1'b1 && n < 100) begin
      rand_inputs(1'b0);
      cycle();
      n++;
    end
    check(tag, 64'(n), 64'(DEPTH));
  endtask

  initial begin
    idle();
    mp_rst_in = 1'b1;
    repeat (2) begin
      @(posedge mp_clk_in);
      update_model();
    end
    #1;

    // T1: one-cycle reset, sweep length, every register reads RESET_VAL.
    mp_rst_in = 1'b1;
    cycle();
    mp_rst_in = 1'b0;
    wait_ready("t1_rdy_latency");
    idle();
    for (int i = 0; i < DEPTH; i += 2) begin
      rs_addr = {AW'(i + 1), AW'(i)};
      settle();
      check("t1_sweep_val", 64'(rs_data[63:32]), 64'(RVAL));
      clk_edge();
    end

    // T2: bypass of a same-cycle write, then array visibility.
    wr_eb = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; rs_addr = {5'd0, 5'd5};
    settle();
    check("t2_bypass", 64'(rs_data[31:0]), 64'hDEAD_BEEF);
    check("t2_nobypass", 64'(nb_data[31:0]), 64'(RVAL));
    clk_edge();
    wr_eb = 1'b0;
    settle();
    check("t2_after_byp", 64'(rs_data[31:0]), 64'hDEAD_BEEF);
    check("t2_after_nobyp", 64'(nb_data[31:0]), 64'hDEAD_BEEF);
    clk_edge();

    // T3: x0 ignores writes and issues.
    wr_eb = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; iss_vld = 1'b1; iss_rd = 5'd0;
    rs_addr = '0; rs_req = 2'b11;
    settle();
    check("t3_x0_same", 64'(rs_data[31:0]), 64'h0);
    clk_edge();
    idle(); rs_req = 2'b11;
    settle();
    check("t3_x0_read", 64'(rs_data), 64'h0);
    check("t3_x0_stall", 64'(stall), 64'h0);
    clk_edge();

    // T4: issue x7, stall on need, forward clears busy, no stall unrequested.
    idle(); iss_vld = 1'b1; iss_rd = 5'd7;
    cycle();
    idle(); rs_addr = {5'd7, 5'd0}; rs_req = 2'b10;
    settle();
    check("t4_stall", 64'(stall), 64'h1);
    check("t4_busy", 64'(rs_busy[1]), 64'h1);
    clk_edge();
    wr_eb = 1'b1; wr_addr = 5'd7; wr_data = 32'd9;
    settle();
    check("t4_fwd_busy", 64'(rs_busy[1]), 64'h0);
    check("t4_fwd_data", 64'(rs_data[63:32]), 64'd9);
    check("t4_fwd_stall", 64'(stall), 64'h0);
    clk_edge();
    idle(); iss_vld = 1'b1; iss_rd = 5'd7;
    cycle();
    idle(); rs_addr = {5'd7, 5'd0}; rs_req = 2'b00;
    settle();
    check("t4_noreq_stall", 64'(stall), 64'h0);
    check("t4_noreq_busy", 64'(rs_busy[1]), 64'h1);
    clk_edge();
    idle(); wr_eb = 1'b1; wr_addr = 5'd7; wr_data = 32'd10;
    cycle();

    // T5: issue and write to the same register in one cycle; set wins.
    idle(); iss_vld = 1'b1; iss_rd = 5'd3; wr_eb = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    cycle();
    idle(); rs_addr = {5'd0, 5'd3}; rs_req = 2'b01;
    settle();
    check("t5_set_wins", 64'(rs_busy[0]), 64'h1);
    check("t5_data", 64'(rs_data[31:0]), 64'h33);
    clk_edge();
    wr_eb = 1'b1; wr_addr = 5'd3; wr_data = 32'h44;
    cycle();
    wr_eb = 1'b0;
    settle();
    check("t5_cleared", 64'(rs_busy[0]), 64'h0);
    check("t5_new_data", 64'(rs_data[31:0]), 64'h44);
    clk_edge();

    // T6: reset mid-sweep restarts it; busy bits come back cleared.
    idle(); iss_vld = 1'b1; iss_rd = 5'd9;
    cycle();
    mp_rst_in = 1'b1;
    cycle();
    mp_rst_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_inputs(1'b0);
      cycle();
    end
    mp_rst_in = 1'b1;
    cycle();
    mp_rst_in = 1'b0;
    wait_ready("t6_rdy_latency");
    idle(); rs_addr = {5'd9, 5'd5}; rs_req = 2'b11;
    settle();
    check("t6_busy_clear", 64'(rs_busy), 64'h0);
    check("t6_resweep", 64'(rs_data[31:0]), 64'(RVAL));
    check("t6_stall", 64'(stall), 64'h0);
    clk_edge();

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs(1'b1);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
